ultrasonic_ctrl: RTL and testbench

- Command sequencer between the command decoder and the transducer datapath (DAC, TX pulser, RX gate).
- Consumes the decoder's registered one-hot command flags plus amount, qualified by valid.
- Owns the power state, slews the DAC level toward a saturated target, and times TX bursts and RX listen windows.
- Reports busy and rejected commands.

---
 rtl/ultrasonic_ctrl_if.sv | 32 +++
 rtl/ultrasonic_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ultrasonic_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ultrasonic_ctrl_if.sv
// Command/status bundle between the command decoder (master) and the
// ultrasonic sequencer (slave). Flags are one-hot-ish and qualified by valid.
interface ultrasonic_ctrl_if #(
    parameter int AMOUNT_WIDTH = 8
);
    logic                    on;
    logic                    off;
    logic                    increase;
    logic                    decrease;
    logic                    receive;
    logic                    send;
    logic                    valid;
    logic [AMOUNT_WIDTH-1:0] amount;

    logic [AMOUNT_WIDTH-1:0] dac_level;
    logic                    dac_wr;
    logic                    tx_en;
    logic                    rx_en;
    logic                    powered;
    logic                    busy;
    logic                    cmd_drop;

    modport master (
        output on, off, increase, decrease, receive, send, valid, amount,
        input  dac_level, dac_wr, tx_en, rx_en, powered, busy, cmd_drop
    );

    modport slave (
        input  on, off, increase, decrease, receive, send, valid, amount,
        output dac_level, dac_wr, tx_en, rx_en, powered, busy, cmd_drop
    );
endinterface

// File: rtl/ultrasonic_ctrl.sv
// Ultrasonic command sequencer: owns power state, slews the DAC level toward
// a saturated target, and times TX bursts and RX listen windows.
module ultrasonic_ctrl #(
    parameter int AMOUNT_WIDTH = 8,
    parameter int MAX_LEVEL    = 200,
    parameter int STEP         = 4,
    parameter int TX_CYCLES    = 16,
    parameter int RX_CYCLES    = 64
) (
    input  logic               clk,
    input  logic               rst,
    ultrasonic_ctrl_if.slave   bus
);
    localparam int W       = AMOUNT_WIDTH;
    localparam int CNT_MAX = (TX_CYCLES > RX_CYCLES) ? TX_CYCLES : RX_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [W:0]       MAX_EXT  = (W+1)'(MAX_LEVEL);
    localparam logic [W:0]       STEP_EXT = (W+1)'(STEP);
    localparam logic [CNT_W-1:0] TX_LOAD  = CNT_W'(TX_CYCLES - 1);
    localparam logic [CNT_W-1:0] RX_LOAD  = CNT_W'(RX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_IDLE,
        S_RAMP,
        S_TX,
        S_RX
    } state_t;

    state_t           state;
    logic [W-1:0]     level;
    logic [W-1:0]     target;
    logic [CNT_W-1:0] cnt;
    logic             rx_after;
    logic             dac_wr;
    logic             tx_en;
    logic             rx_en;
    logic             powered;
    logic             busy;
    logic             cmd_drop;

    logic             work;
    logic [W:0]       sum_ext;
    logic [W-1:0]     new_target;
    logic [W-1:0]     diff;
    logic [W-1:0]     ramp_next;

    assign work    = bus.increase | bus.decrease | bus.send | bus.receive;
    assign sum_ext = {1'b0, level} + {1'b0, bus.amount};

    // Saturated target for increase (ceiling MAX_LEVEL) or decrease (floor 0)
    always_comb begin
        new_target = level;
        if (bus.increase) begin
            new_target = (sum_ext > MAX_EXT) ? MAX_EXT[W-1:0] : sum_ext[W-1:0];
        end else if (bus.decrease) begin
            new_target = (bus.amount >= level) ? '0 : level - bus.amount;
        end
    end

    // Next ramp level: move toward target by at most STEP
    always_comb begin
        diff      = (target > level) ? target - level : level - target;
        ramp_next = target;
        if ({1'b0, diff} > STEP_EXT) begin
            ramp_next = (target > level) ? level + STEP_EXT[W-1:0]
                                         : level - STEP_EXT[W-1:0];
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_OFF;
            level    <= '0;
            target   <= '0;
            cnt      <= '0;
            rx_after <= 1'b0;
            dac_wr   <= 1'b0;
            tx_en    <= 1'b0;
            rx_en    <= 1'b0;
            powered  <= 1'b0;
            busy     <= 1'b0;
            cmd_drop <= 1'b0;
        end else begin
            dac_wr   <= 1'b0;
            cmd_drop <= 1'b0;
            if (state == S_OFF) begin
                if (bus.valid && bus.on) begin
                    state   <= S_IDLE;
                    powered <= 1'b1;
                end else if (bus.valid && work) begin
                    cmd_drop <= 1'b1;
                end
            end else if (bus.valid && bus.off) begin
                // off preempts any activity, including a pending ramp or window
                state    <= S_OFF;
                dac_wr   <= (level != '0);
                level    <= '0;
                target   <= '0;
                cnt      <= '0;
                rx_after <= 1'b0;
                tx_en    <= 1'b0;
                rx_en    <= 1'b0;
                powered  <= 1'b0;
                busy     <= 1'b0;
            end else begin
                // on is inapplicable once powered, so lower-priority flags still act
                unique case (state)
                    S_IDLE: begin
                        if (bus.valid && (bus.increase || bus.decrease)) begin
                            target <= new_target;
                            if (new_target != level) begin
                                state <= S_RAMP;
                                busy  <= 1'b1;
                            end
                        end else if (bus.valid && bus.send) begin
                            state    <= S_TX;
                            tx_en    <= 1'b1;
                            cnt      <= TX_LOAD;
                            rx_after <= bus.receive;
                            busy     <= 1'b1;
                        end else if (bus.valid && bus.receive) begin
                            state <= S_RX;
                            rx_en <= 1'b1;
                            cnt   <= RX_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    S_RAMP: begin
                        cmd_drop <= bus.valid && work;
                        level    <= ramp_next;
                        dac_wr   <= 1'b1;
                        if (ramp_next == target) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    S_TX: begin
                        cmd_drop <= bus.valid && work;
                        if (cnt == '0) begin
                            tx_en <= 1'b0;
                            if (rx_after) begin
                                state    <= S_RX;
                                rx_en    <= 1'b1;
                                cnt      <= RX_LOAD;
                                rx_after <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_RX: begin
                        cmd_drop <= bus.valid && work;
                        if (cnt == '0) begin
                            rx_en <= 1'b0;
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= S_OFF;
                    end
                endcase
            end
        end
    end

    assign bus.dac_level = level;
    assign bus.dac_wr    = dac_wr;
    assign bus.tx_en     = tx_en;
    assign bus.rx_en     = rx_en;
    assign bus.powered   = powered;
    assign bus.busy      = busy;
    assign bus.cmd_drop  = cmd_drop;
endmodule

// File: tb/tb_ultrasonic_ctrl.sv
// Bench for ultrasonic_ctrl: directed literal checks plus randomized traffic
// compared every cycle against an abstract activity model.
module tb_ultrasonic_ctrl;
    localparam int AW   = 8;
    localparam int MAXL = 200;
    localparam int STP  = 4;
    localparam int TXC  = 16;
    localparam int RXC  = 64;

    localparam logic [5:0] F_OFF = 6'b100000;
    localparam logic [5:0] F_ON  = 6'b010000;
    localparam logic [5:0] F_INC = 6'b001000;
    localparam logic [5:0] F_DEC = 6'b000100;
    localparam logic [5:0] F_SND = 6'b000010;
    localparam logic [5:0] F_RCV = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ultrasonic_ctrl_if #(.AMOUNT_WIDTH(AW)) bus ();

    ultrasonic_ctrl #(
        .AMOUNT_WIDTH(AW),
        .MAX_LEVEL(MAXL),
        .STEP(STP),
        .TX_CYCLES(TXC),
        .RX_CYCLES(RXC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Abstract model: power flag, level/target, remaining TX and RX cycles
    int m_level  = 0;
    int m_target = 0;
    int m_tx     = 0;
    int m_rx     = 0;
    bit m_pwr    = 0;
    bit m_wr     = 0;
    bit m_drop   = 0;
    bit m_ready  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic model_step();
        int  d;
        bit  work;
        bit  was_busy;
        int  amt;
        work = bus.increase || bus.decrease || bus.send || bus.receive;
        amt  = int'(bus.amount);
        m_wr   = 0;
        m_drop = 0;
        if (rst) begin
            m_level = 0; m_target = 0; m_tx = 0; m_rx = 0; m_pwr = 0;
        end else if (!m_pwr) begin
            if (bus.valid && bus.on) m_pwr = 1;
            else if (bus.valid && work) m_drop = 1;
        end else if (bus.valid && bus.off) begin
            m_wr = (m_level != 0);
            m_level = 0; m_target = 0; m_tx = 0; m_rx = 0; m_pwr = 0;
        end else begin
            was_busy = (m_level != m_target) || (m_tx > 0) || (m_rx > 0);
            if (m_level != m_target) begin
                d = m_target - m_level;
                if (d > STP) d = STP;
                if (d < -STP) d = -STP;
                m_level = m_level + d;
                m_wr = 1;
            end else if (m_tx > 0) begin
                m_tx--;
            end else if (m_rx > 0) begin
                m_rx--;
            end
            if (bus.valid && work) begin
                if (was_busy) m_drop = 1;
                else if (bus.increase) m_target = (m_level + amt > MAXL) ? MAXL : m_level + amt;
                else if (bus.decrease) m_target = (m_level - amt < 0) ? 0 : m_level - amt;
                else if (bus.send) begin
                    m_tx = TXC;
                    m_rx = bus.receive ? RXC : 0;
                end else m_rx = RXC;
            end
        end
        m_ready = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_ready) begin
            chk("dac_level", 32'(bus.dac_level), 32'(m_level));
            chk("dac_wr",    32'(bus.dac_wr),    32'(m_wr));
            chk("tx_en",     32'(bus.tx_en),     32'(m_tx > 0));
            chk("rx_en",     32'(bus.rx_en),     32'(m_tx == 0 && m_rx > 0));
            chk("powered",   32'(bus.powered),   32'(m_pwr));
            chk("busy",      32'(bus.busy),      32'(m_level != m_target || m_tx > 0 || m_rx > 0));
            chk("cmd_drop",  32'(bus.cmd_drop),  32'(m_drop));
        end
    end

    task automatic drive(input logic [5:0] f, input int a, input logic v);
        bus.off      = f[5];
        bus.on       = f[4];
        bus.increase = f[3];
        bus.decrease = f[2];
        bus.send     = f[1];
        bus.receive  = f[0];
        bus.amount   = 8'(a);
        bus.valid    = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input int a);
        step();
        drive(f, a, 1'b1);
        step();
        drive(6'b0, 0, 1'b0);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (bus.busy === 1'b1 && g < 300) begin
            step();
            g++;
        end
        if (g >= 300) chk("idle_timeout", 32'(g), 32'(0));
    endtask

    task automatic count_while_tx(output int n);
        n = 0;
        while (bus.tx_en === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic count_while_rx(output int n);
        n = 0;
        while (bus.rx_en === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        int g;
        drive(6'b0, 0, 1'b0);
        rst = 1'b1;
        step();
        step();
        chk("rst_level",   32'(bus.dac_level), 32'd0);
        chk("rst_powered", 32'(bus.powered),   32'd0);
        chk("rst_tx",      32'(bus.tx_en),     32'd0);
        rst = 1'b0;

        issue(F_ON, 0);
        chk("on_powered", 32'(bus.powered), 32'd1);
        chk("on_busy",    32'(bus.busy),    32'd0);
        chk("on_wr",      32'(bus.dac_wr),  32'd0);

        issue(F_INC, 10);
        chk("ramp_busy", 32'(bus.busy), 32'd1);
        step(); chk("ramp_4",  32'(bus.dac_level), 32'd4);
        chk("ramp_4_wr", 32'(bus.dac_wr), 32'd1);
        step(); chk("ramp_8",  32'(bus.dac_level), 32'd8);
        step(); chk("ramp_10", 32'(bus.dac_level), 32'd10);
        chk("ramp_10_wr",  32'(bus.dac_wr), 32'd1);
        chk("ramp_done",   32'(bus.busy),   32'd0);

        issue(F_INC, 188);
        wait_idle();
        chk("level_198", 32'(bus.dac_level), 32'd198);
        issue(F_INC, 255);
        step();
        chk("sat_200", 32'(bus.dac_level), 32'd200);
        chk("sat_idle", 32'(bus.busy), 32'd0);

        issue(F_DEC, 197);
        wait_idle();
        chk("level_3", 32'(bus.dac_level), 32'd3);
        issue(F_DEC, 9);
        step();
        chk("floor_0", 32'(bus.dac_level), 32'd0);
        chk("floor_wr", 32'(bus.dac_wr), 32'd1);

        issue(F_SND | F_RCV, 0);
        count_while_tx(n);
        chk("echo_tx_len", 32'(n), 32'd16);
        chk("echo_no_gap", 32'(bus.rx_en), 32'd1);
        count_while_rx(n);
        chk("echo_rx_len", 32'(n), 32'd64);
        chk("echo_idle", 32'(bus.busy), 32'd0);

        issue(F_INC, 20);
        wait_idle();
        issue(F_SND, 0);
        step(); step(); step();
        issue(F_INC, 5);
        chk("drop_pulse", 32'(bus.cmd_drop), 32'd1);
        count_while_tx(n);
        chk("drop_tx_rest", 32'(n), 32'd11);
        chk("drop_level", 32'(bus.dac_level), 32'd20);

        issue(F_SND, 0);
        step(); step(); step(); step();
        issue(F_OFF, 0);
        chk("pre_tx",    32'(bus.tx_en),     32'd0);
        chk("pre_pwr",   32'(bus.powered),   32'd0);
        chk("pre_level", 32'(bus.dac_level), 32'd0);
        chk("pre_wr",    32'(bus.dac_wr),    32'd1);

        issue(F_ON, 0);
        issue(F_INC, 20);
        wait_idle();
        issue(F_INC, 80);
        g = 0;
        while (bus.dac_level !== 8'd40 && g < 50) begin
            step();
            g++;
        end
        chk("mid_ramp_40", 32'(bus.dac_level), 32'd40);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ramp_level", 32'(bus.dac_level), 32'd0);
        chk("rst_ramp_wr",    32'(bus.dac_wr),    32'd0);
        chk("rst_ramp_pwr",   32'(bus.powered),   32'd0);
        chk("rst_ramp_busy",  32'(bus.busy),      32'd0);

        for (int i = 0; i < 4000; i++) begin
            logic [5:0] f;
            f[5] = ($urandom_range(0, 23) == 0);
            f[4] = ($urandom_range(0, 3) == 0);
            f[3] = ($urandom_range(0, 3) == 0);
            f[2] = ($urandom_range(0, 3) == 0);
            f[1] = ($urandom_range(0, 3) == 0);
            f[0] = ($urandom_range(0, 3) == 0);
            drive(f, ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255)),
                  logic'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        drive(6'b0, 0, 1'b0);
        step();
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
